// File: rtl/decode_inst_queue.sv
// Fetch-to-decode instruction FIFO. Each entry carries its PC, the instruction
// word and a branch-delay-slot flag derived from the previously enqueued instruction.
module decode_inst_queue #(
    parameter  int DEPTH  = 4,
    parameter  int PC_W   = 32,
    parameter  int INST_W = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fe_valid,
    input  logic [PC_W-1:0]   fe_pc,
    input  logic [INST_W-1:0] fe_inst,
    output logic              fe_allowin,
    input  logic              flush,
    input  logic              de_allowin,
    output logic              de_valid,
    output logic [PC_W-1:0]   de_pc,
    output logic [INST_W-1:0] de_inst,
    output logic              de_bd,
    output logic [CNT_W-1:0]  de_count
);

    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [DEPTH-1:0]  bd_mem_q;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             prev_branch_q, prev_branch_d;

    logic       enq, deq, is_branch;
    logic [5:0] op, func;
    logic [4:0] rt;

    // Only opcode, rt and func fields matter; the remaining bits feed this sink.
    logic unused_inst_bits;
    assign unused_inst_bits = ^fe_inst;

    assign op   = fe_inst[31:26];
    assign rt   = fe_inst[20:16];
    assign func = fe_inst[5:0];

    always_comb begin
        is_branch = 1'b0;
        case (op)
            6'b000010, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111: is_branch = 1'b1;
            6'b000001: is_branch = (rt == 5'b00000) || (rt == 5'b00001) ||
                                   (rt == 5'b10000) || (rt == 5'b10001);
            6'b000000: is_branch = (func == 6'b001000) || (func == 6'b001001);
            default:   is_branch = 1'b0;
        endcase
    end

    assign fe_allowin = (count_q != CNT_W'(DEPTH));
    assign de_valid   = (count_q != '0);
    assign enq        = fe_valid & fe_allowin & ~flush;
    assign deq        = de_valid & de_allowin & ~flush;

    assign de_pc    = pc_mem_q[rd_ptr_q];
    assign de_inst  = inst_mem_q[rd_ptr_q];
    assign de_bd    = bd_mem_q[rd_ptr_q];
    assign de_count = count_q;

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        prev_branch_d = prev_branch_q;
        if (flush) begin
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            prev_branch_d = 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_d      = wr_ptr_q + PTR_W'(1);
                prev_branch_d = is_branch;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            prev_branch_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            prev_branch_q <= prev_branch_d;
        end
    end

    // Storage written at the tail; the bd bit reflects the instruction enqueued before this one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
            bd_mem_q <= '0;
        end else if (enq) begin
            pc_mem_q[wr_ptr_q]   <= fe_pc;
            inst_mem_q[wr_ptr_q] <= fe_inst;
            bd_mem_q[wr_ptr_q]   <= prev_branch_q;
        end
    end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Directed bench for decode_inst_queue: reset, fill/drain, wrap, delay-slot tagging, flush.
module tb_decode_inst_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] ADDU   = 32'h0022_1821;
    localparam logic [31:0] BEQ    = 32'h1022_0003;
    localparam logic [31:0] JR     = 32'h03E0_0008;
    localparam logic [31:0] JALR   = 32'h0040_F809;
    localparam logic [31:0] BGEZAL = 32'h0411_0004;
    localparam logic [31:0] REGIMM_NB = 32'h0402_0004;
    localparam logic [31:0] J      = 32'h0800_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              fe_valid;
    logic [PC_W-1:0]   fe_pc;
    logic [INST_W-1:0] fe_inst;
    logic              fe_allowin;
    logic              flush;
    logic              de_allowin;
    logic              de_valid;
    logic [PC_W-1:0]   de_pc;
    logic [INST_W-1:0] de_inst;
    logic              de_bd;
    logic [CNT_W-1:0]  de_count;

    int n_checks = 0;
    int n_fail   = 0;

    decode_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .fe_valid   (fe_valid),
        .fe_pc      (fe_pc),
        .fe_inst    (fe_inst),
        .fe_allowin (fe_allowin),
        .flush      (flush),
        .de_allowin (de_allowin),
        .de_valid   (de_valid),
        .de_pc      (de_pc),
        .de_inst    (de_inst),
        .de_bd      (de_bd),
        .de_count   (de_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_only(input logic [31:0] pc, input logic [31:0] inst);
        fe_valid   = 1'b1;
        fe_pc      = pc;
        fe_inst    = inst;
        de_allowin = 1'b0;
        tick();
        fe_valid   = 1'b0;
    endtask

    task automatic deq_expect(input string tag, input logic [31:0] pc, input logic bd);
        check_eq({tag, "_valid"}, 64'(de_valid), 64'(1));
        check_eq({tag, "_pc"}, 64'(de_pc), 64'(pc));
        check_eq({tag, "_bd"}, 64'(de_bd), 64'(bd));
        de_allowin = 1'b1;
        tick();
        de_allowin = 1'b0;
    endtask

    logic [31:0] ds_inst [11];
    logic        ds_bd   [11];
    logic [31:0] head_pc, tail_pc;

    initial begin
        reset = 1'b1; fe_valid = 1'b0; fe_pc = '0; fe_inst = '0;
        flush = 1'b0; de_allowin = 1'b0;
        #2;
        check_eq("rst_valid", 64'(de_valid), 64'(0));
        check_eq("rst_count", 64'(de_count), 64'(0));
        check_eq("rst_allowin", 64'(fe_allowin), 64'(1));
        check_eq("rst_pc", 64'(de_pc), 64'(0));
        check_eq("rst_inst", 64'(de_inst), 64'(0));
        #20 reset = 1'b0;
        tick();

        // Fill to full, then a refused fifth entry.
        for (int i = 0; i < 4; i++) begin
            enq_only(32'hBFC0_0000 + 32'(4 * i), NOP);
            check_eq("fill_count", 64'(de_count), 64'(i + 1));
        end
        check_eq("full_allowin", 64'(fe_allowin), 64'(0));
        fe_valid = 1'b1; fe_pc = 32'hBFC0_0010; fe_inst = NOP;
        tick();
        fe_valid = 1'b0;
        check_eq("full_count", 64'(de_count), 64'(4));
        check_eq("full_head", 64'(de_pc), 64'hBFC0_0000);
        // Full with dequeue: enqueue still refused.
        fe_valid = 1'b1; de_allowin = 1'b1;
        tick();
        fe_valid = 1'b0; de_allowin = 1'b0;
        check_eq("full_deq_count", 64'(de_count), 64'(3));
        check_eq("full_deq_head", 64'(de_pc), 64'hBFC0_0004);
        for (int i = 1; i < 4; i++) deq_expect("drain", 32'hBFC0_0000 + 32'(4 * i), 1'b0);
        check_eq("drain_valid", 64'(de_valid), 64'(0));
        de_allowin = 1'b1;
        tick();
        de_allowin = 1'b0;
        check_eq("underflow_count", 64'(de_count), 64'(0));

        // Asynchronous reset mid-cycle with entries queued.
        enq_only(32'h0000_0500, BEQ);
        enq_only(32'h0000_0504, NOP);
        #2 reset = 1'b1;
        #1;
        check_eq("async_valid", 64'(de_valid), 64'(0));
        check_eq("async_count", 64'(de_count), 64'(0));
        check_eq("async_allowin", 64'(fe_allowin), 64'(1));
        check_eq("async_pc", 64'(de_pc), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_valid", 64'(de_valid), 64'(0));

        // Two entries in flight across the pointer wrap.
        enq_only(32'h0000_1000, NOP);
        enq_only(32'h0000_1004, NOP);
        head_pc = 32'h0000_1000;
        tail_pc = 32'h0000_1008;
        for (int i = 0; i < 10; i++) begin
            check_eq("wrap_head", 64'(de_pc), 64'(head_pc));
            check_eq("wrap_count", 64'(de_count), 64'(2));
            fe_valid = 1'b1; fe_pc = tail_pc; fe_inst = NOP; de_allowin = 1'b1;
            tick();
            head_pc += 4;
            tail_pc += 4;
        end
        fe_valid = 1'b0; de_allowin = 1'b0;
        deq_expect("wrap_drain0", head_pc, 1'b0);
        deq_expect("wrap_drain1", head_pc + 32'd4, 1'b0);
        check_eq("wrap_empty", 64'(de_valid), 64'(0));

        // Simultaneous enq/deq at count 1.
        enq_only(32'h0000_2000, NOP);
        fe_valid = 1'b1; fe_pc = 32'h0000_2004; fe_inst = NOP; de_allowin = 1'b1;
        tick();
        fe_valid = 1'b0; de_allowin = 1'b0;
        check_eq("c1_count", 64'(de_count), 64'(1));
        check_eq("c1_head", 64'(de_pc), 64'h0000_2004);
        deq_expect("c1_drain", 32'h0000_2004, 1'b0);

        // Delay-slot tagging: three queued, then a mixed table enqueued one at a time.
        enq_only(32'h0000_0100, BEQ);
        enq_only(32'h0000_0104, ADDU);
        enq_only(32'h0000_0108, ADDU);
        check_eq("ds_count", 64'(de_count), 64'(3));
        deq_expect("ds_beq", 32'h0000_0100, 1'b0);
        deq_expect("ds_slot", 32'h0000_0104, 1'b1);
        deq_expect("ds_after", 32'h0000_0108, 1'b0);
        ds_inst = '{JR, ADDU, ADDU, BGEZAL, ADDU, REGIMM_NB, ADDU, JALR, ADDU, J, ADDU};
        ds_bd   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            enq_only(32'h0000_0200 + 32'(4 * i), ds_inst[i]);
            check_eq("ds_inst", 64'(de_inst), 64'(ds_inst[i]));
            deq_expect("ds_tbl", 32'h0000_0200 + 32'(4 * i), ds_bd[i]);
        end

        // Flush beats concurrent enq and deq and clears the branch history.
        enq_only(32'h0000_0300, NOP);
        enq_only(32'h0000_0304, NOP);
        enq_only(32'h0000_0308, J);
        check_eq("pre_flush_count", 64'(de_count), 64'(3));
        flush = 1'b1; fe_valid = 1'b1; fe_pc = 32'h0000_030C; fe_inst = ADDU; de_allowin = 1'b1;
        tick();
        flush = 1'b0; fe_valid = 1'b0; de_allowin = 1'b0;
        check_eq("flush_count", 64'(de_count), 64'(0));
        check_eq("flush_valid", 64'(de_valid), 64'(0));
        check_eq("flush_allowin", 64'(fe_allowin), 64'(1));
        enq_only(32'h0000_0400, ADDU);
        check_eq("flush_next_count", 64'(de_count), 64'(1));
        deq_expect("flush_next", 32'h0000_0400, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Parametrised instruction buffer between the fetch stage and the decode stage.
- Replaces the direct fetch-to-decode hand-off with a DEPTH-entry FIFO of {pc, inst, bd} entries, using valid/allowin handshakes on both sides.
- Each entry is tagged with a branch-delay-slot flag (bd). Decode/CP0 logic uses it for EPC/Cause.BD on exceptions.
- A flush input (exception or ERET) empties the queue in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PC_W, 32, PC width.
- INST_W, 32, instruction width; bits [31:26], [20:16] and [5:0] must exist (INST_W >= 32).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fe_valid  in  1  fetch presents an instruction this cycle.
- fe_pc  in  PC_W  PC of the presented instruction.
- fe_inst  in  INST_W  presented instruction word.
- fe_allowin  out  1  queue can accept an entry this cycle.
- flush  in  1  exception/ERET taken; discard all entries.
- de_allowin  in  1  decode consumes the head entry this cycle.
- de_valid  out  1  head entry valid.
- de_pc  out  PC_W  PC of the head entry.
- de_inst  out  INST_W  instruction of the head entry.
- de_bd  out  1  head entry is in a branch delay slot.
- de_count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Handshakes:
  - enq = fe_valid & fe_allowin & ~flush.
  - deq = de_valid & de_allowin & ~flush.
- Reset (async, while high):
  - rd_ptr = wr_ptr = 0, count = 0, prev_branch = 0, all storage zeroed.
  - Outputs: de_valid 0, de_pc 0, de_inst 0, de_bd 0, de_count 0, fe_allowin 1.
  - Reset deasserted mid-stream: the queue restarts empty; no stale entry is ever presented.
- fe_allowin = (count != DEPTH). There is no pass-through when full: a full queue refuses enqueue even if a dequeue happens the same cycle.
- de_valid = (count != 0). de_pc, de_inst and de_bd are read from storage[rd_ptr], a first-word-fall-through view.
- Latency: an entry enqueued at edge N is visible on de_* after edge N. There is no empty-queue bypass, so minimum fetch-to-decode latency is 1 cycle.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 on enq only.
  - -1 on deq only.
  - unchanged on simultaneous enq and deq (legal when 0 < count < DEPTH).
- Branch class (decoded from fe_inst):
  - op 000010 J, 000011 JAL, 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ.
  - op 000001 with rt in {00000, 00001, 10000, 10001}.
  - op 000000 with func 001000 JR or 001001 JALR.
- bd tagging:
  - On enq, the entry's bd bit = prev_branch.
  - prev_branch <= branch_class(fe_inst) on every enq; it is held otherwise.
- Flush has priority over everything in the same cycle:
  - rd_ptr = wr_ptr = 0, count = 0, prev_branch = 0.
  - Any concurrent enq or deq is discarded and not counted.
  - Storage contents need not be cleared.
  - de_valid = 0 the cycle after flush.
- Enqueue with fe_valid=1 while full: ignored. Fetch must hold fe_pc/fe_inst until fe_allowin=1.
- de_allowin while empty: no effect. Count never underflows.
- The queue does no decoding beyond the branch-class check.

Test Plan:
- Reset/idle: assert reset asynchronously mid-cycle -> de_valid=0, de_count=0, fe_allowin=1 immediately, without waiting for a clock edge.
- Fill/drain, DEPTH=4, de_allowin=0: enqueue pc 0xBFC00000..0xBFC0000C -> de_count reaches 4 and fe_allowin=0. A 5th fe_valid is ignored. Then de_allowin=1 -> heads appear in order 0xBFC00000, 04, 08, 0C; de_valid=0 after the 4th.
- Wrap-around: keep 2 entries in flight with simultaneous enq/deq for 10 cycles -> de_count stays 2, PCs stay strictly sequential, no entry lost or duplicated across the pointer wrap.
- Delay slot: enqueue BEQ (0x10220003) @0x100, ADDU @0x104, ADDU @0x108 -> de_bd = 0, 1, 0. Repeat with JR (0x03E00008) -> the slot after it has de_bd=1.
- Flush priority: 3 entries queued, last one a J; in one cycle assert flush with fe_valid=1 and de_allowin=1 -> next cycle de_count=0, de_valid=0. The next enqueued instruction has de_bd=0.
- Simultaneous enq/deq at count=1 -> count stays 1, and the head becomes the newly enqueued entry one cycle later.
